// File: rtl/router_pkg.sv
// Shared encodings and sizing for the 1x3 router control path.
package router_pkg;
  localparam int NUM_DEST = 3;
  localparam int ADDR_W   = 2;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Per-port flag select; an out-of-range address reads as 0.
  function automatic logic sel_bit(logic [NUM_DEST-1:0] v, logic [ADDR_W-1:0] idx);
    sel_bit = 1'b0;
    for (int i = 0; i < NUM_DEST; i++)
      if (idx == ADDR_W'(i)) sel_bit = v[i];
  endfunction
endpackage

// File: rtl/router_fsm_if.sv
// Handshake/status bundle between packet source, router_reg, FIFOs and router_fsm.
interface router_fsm_if;
  import router_pkg::*;

  logic                pkt_valid;
  logic [ADDR_W-1:0]   data_in;
  logic                fifo_full;
  logic [NUM_DEST-1:0] fifo_empty;
  logic [NUM_DEST-1:0] soft_reset;
  logic                parity_done;
  logic                low_packet_valid;

  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic rst_int_reg, write_enb_reg, busy;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Moore control FSM for the 1x3 router: decodes the header, waits for the
// target FIFO, tracks back-pressure and honours per-port soft resets.
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  router_fsm_if.slave bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sel_empty_hdr, sel_empty_q, sel_srst;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign sel_empty_hdr = sel_bit(bus.fifo_empty, bus.data_in);
  assign sel_empty_q   = sel_bit(bus.fifo_empty, addr_q);
  assign sel_srst      = sel_bit(bus.soft_reset, addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE_ADDRESS && bus.pkt_valid) addr_d = bus.data_in;

    unique case (state_q)
      DECODE_ADDRESS:
        if (bus.pkt_valid && bus.data_in != INVALID_ADDR)
          state_d = sel_empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (sel_empty_q) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        state_d = LOAD_DATA;
      LOAD_DATA:
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (bus.parity_done)           state_d = DECODE_ADDRESS;
        else if (bus.low_packet_valid) state_d = LOAD_PARITY;
        else                           state_d = LOAD_DATA;
      LOAD_PARITY:
        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        state_d = DECODE_ADDRESS;
    endcase

    // A read timeout on the selected port abandons the packet from any state.
    if (state_q != DECODE_ADDRESS && sel_srst) state_d = DECODE_ADDRESS;
  end

  assign bus.detect_add    = (state_q == DECODE_ADDRESS);
  assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_q == LOAD_DATA);
  assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
  assign bus.full_state    = (state_q == FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                             (state_q == LOAD_AFTER_FULL);
  assign bus.busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
endmodule

// File: tb/tb_router_fsm.sv
// Table-driven, hand-sequenced and randomized checks of router_fsm.
module tb_router_fsm;
  logic clock = 1'b0;
  logic resetn;
  router_fsm_if bus ();

  router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));

  always #5 clock = ~clock;

  // Output vectors: {detect, lfd, ld, laf, full, rst_int, we, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0010;
  localparam logic [7:0] O_LP  = 8'b0000_0011;
  localparam logic [7:0] O_CPE = 8'b0000_0101;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  // Reference model: phase names independent of the DUT encoding.
  localparam int DA = 0, LFD = 1, LD = 2, LP = 3, FFS = 4, LAF = 5, WTE = 6, CPE = 7;
  logic [7:0] exp_of [8];
  int m_state;
  int m_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [7:0] got();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    checks++;
    if (got() !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", name, got(), exp);
    end
  endtask

  // Next phase from the behavioural rules, including reset and soft-reset priority.
  function automatic int model_next(int s, int a);
    int n;
    if (!resetn) return DA;
    if (s != DA && a < 3 && bus.soft_reset[a]) return DA;
    n = s;
    case (s)
      DA:  if (bus.pkt_valid && bus.data_in != 2'b11)
             n = bus.fifo_empty[bus.data_in] ? LFD : WTE;
      WTE: if (bus.fifo_empty[a]) n = LFD;
      LFD: n = LD;
      LD:  n = bus.fifo_full ? FFS : (!bus.pkt_valid ? LP : LD);
      FFS: n = bus.fifo_full ? FFS : LAF;
      LAF: n = bus.parity_done ? DA : (bus.low_packet_valid ? LP : LD);
      LP:  n = CPE;
      CPE: n = bus.fifo_full ? FFS : DA;
      default: n = DA;
    endcase
    return n;
  endfunction

  task automatic step();
    int ns;
    @(posedge clock);
    ns = model_next(m_state, m_addr);
    if (!resetn) m_addr = 0;
    else if (m_state == DA && bus.pkt_valid) m_addr = int'(bus.data_in);
    m_state = ns;
    #1;
  endtask

  task automatic set_in(input logic pv, input logic [1:0] din, input logic full,
                        input logic [2:0] empty, input logic pd, input logic lpv);
    bus.pkt_valid = pv; bus.data_in = din; bus.fifo_full = full;
    bus.fifo_empty = empty; bus.parity_done = pd; bus.low_packet_valid = lpv;
  endtask

  function automatic vec_t mk(logic pv, logic [1:0] din, logic full, logic [2:0] empty,
                              logic pd, logic lpv, logic [7:0] exp, string name);
    vec_t v;
    v.pv = pv; v.din = din; v.full = full; v.empty = empty;
    v.pd = pd; v.lpv = lpv; v.exp = exp; v.name = name;
    return v;
  endfunction

  initial begin
    exp_of[DA] = O_DA;   exp_of[LFD] = O_LFD; exp_of[LD] = O_LD;   exp_of[LP] = O_LP;
    exp_of[FFS] = O_FFS; exp_of[LAF] = O_LAF; exp_of[WTE] = O_WTE; exp_of[CPE] = O_CPE;
    m_state = DA; m_addr = 0;

    // Good packet: header addr 2, 5 LD cycles, parity, check.
    tbl.push_back(mk(1, 2, 0, 3'b111, 0, 0, O_LFD, "good_hdr"));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 3'b111, 0, 0, O_LD, "good_ld"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 0, 0, O_LP,  "good_lp"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 0, 0, O_CPE, "good_cpe"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 0, 0, O_DA,  "good_da"));
    // Busy destination: addr 1 not empty.
    tbl.push_back(mk(1, 1, 0, 3'b101, 0, 0, O_WTE, "wte_enter"));
    tbl.push_back(mk(0, 0, 0, 3'b101, 0, 0, O_WTE, "wte_hold"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 0, 0, O_LFD, "wte_lfd"));
    tbl.push_back(mk(1, 0, 0, 3'b111, 0, 0, O_LD,  "wte_ld"));
    // Back-pressure: 3 full cycles, then the three LAF exits.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 3'b111, 0, 0, O_FFS, "bp_ffs"));
    tbl.push_back(mk(1, 0, 0, 3'b111, 0, 0, O_LAF, "bp_laf"));
    tbl.push_back(mk(1, 0, 0, 3'b111, 0, 0, O_LD,  "bp_laf_ld"));
    tbl.push_back(mk(1, 0, 1, 3'b111, 0, 0, O_FFS, "bp_ffs2"));
    tbl.push_back(mk(1, 0, 0, 3'b111, 0, 0, O_LAF, "bp_laf2"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 0, 1, O_LP,  "bp_laf_lp"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 0, 0, O_CPE, "bp_cpe"));
    tbl.push_back(mk(0, 0, 1, 3'b111, 0, 0, O_FFS, "cpe_full"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 0, 0, O_LAF, "bp_laf3"));
    tbl.push_back(mk(0, 0, 0, 3'b111, 1, 0, O_DA,  "bp_laf_da"));
    // Invalid address stays in DA.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 3, 0, 3'b111, 0, 0, O_DA, "invalid_addr"));

    resetn = 1'b0;
    bus.soft_reset = 3'b000;
    set_in(0, 0, 0, 3'b111, 0, 0);
    step(); step();
    check("reset", O_DA);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].pv, tbl[i].din, tbl[i].full, tbl[i].empty, tbl[i].pd, tbl[i].lpv);
      step();
      check(tbl[i].name, tbl[i].exp);
    end

    // Soft reset: only the selected port (addr 0) aborts.
    set_in(1, 0, 0, 3'b111, 0, 0); step(); check("sr_lfd", O_LFD);
    step(); check("sr_ld", O_LD);
    bus.soft_reset = 3'b010; step(); check("sr_other_port", O_LD);
    bus.soft_reset = 3'b001; step(); check("sr_selected", O_DA);
    bus.soft_reset = 3'b000;

    // Sync reset mid-packet: takes effect only at the edge.
    set_in(1, 2, 0, 3'b111, 0, 0); step(); check("rst_lfd", O_LFD);
    step(); check("rst_ld", O_LD);
    resetn = 1'b0; #2; check("rst_not_before_edge", O_LD);
    step(); check("rst_edge", O_DA);
    resetn = 1'b1;
    step(); check("rst_fresh_hdr", O_LFD);
    step(); check("rst_fresh_ld", O_LD);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      resetn         = ($urandom_range(0, 99) >= 2);
      bus.pkt_valid  = ($urandom_range(0, 99) < 75);
      bus.data_in    = 2'($urandom_range(0, 3));
      bus.fifo_full  = ($urandom_range(0, 99) < 20);
      bus.fifo_empty = 3'($urandom_range(0, 7));
      bus.soft_reset = ($urandom_range(0, 99) < 5) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      bus.parity_done      = ($urandom_range(0, 99) < 20);
      bus.low_packet_valid = ($urandom_range(0, 99) < 20);
      step();
      check("random", exp_of[m_state]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1x3 router datapath. It sequences router_reg by driving detect_add, lfd_state, ld_state, laf_state, full_state and rst_int_reg.
- It also produces the FIFO write enable and the busy (stall) indication back to the packet source.
- It decodes the header destination, waits for the selected output FIFO to drain, tracks FIFO-full back-pressure and honours per-port soft resets.
- Sits between the packet input, router_reg, the three output FIFOs and the synchronizer.

Parameters:
- NUM_DEST, 3, number of output ports. Only 3 is supported; destination address 2'b11 is invalid.
- ADDR_W, 2, width of the destination field, data_in[1:0].

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset, sampled on the rising edge of clock
- pkt_valid  in  1  packet byte valid from source; deasserted on the parity byte
- data_in  in  ADDR_W  header destination bits, data_in[1:0]
- fifo_full  in  1  selected destination FIFO full (from synchronizer)
- fifo_empty  in  NUM_DEST  per-FIFO empty flags
- soft_reset  in  NUM_DEST  per-FIFO soft reset (read timeout)
- parity_done  in  1  from router_reg: parity byte captured
- low_packet_valid  in  1  from router_reg: pkt_valid fell while the FIFO was full
- detect_add  out  1  state == DECODE_ADDRESS
- lfd_state  out  1  state == LOAD_FIRST_DATA
- ld_state  out  1  state == LOAD_DATA
- laf_state  out  1  state == LOAD_AFTER_FULL
- full_state  out  1  state == FIFO_FULL_STATE
- rst_int_reg  out  1  state == CHECK_PARITY_ERROR
- write_enb_reg  out  1  FIFO write enable: asserted in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL
- busy  out  1  stall to source: asserted in every state except DECODE_ADDRESS and LOAD_DATA

Behaviour:
- Structure: Moore machine, one-hot or binary encoding. All outputs decode combinationally from the registered state; no output depends directly on an input.
- Reset: resetn=0 at a rising edge sets state to DECODE_ADDRESS and clears addr_q to 0. Outputs then read detect_add=1, all other outputs 0, busy=0.
- Address latch: addr_q <= data_in when state==DECODE_ADDRESS && pkt_valid. addr_q is held in every other state.
- DECODE_ADDRESS, if pkt_valid && data_in!=3:
  - fifo_empty[data_in]=1 -> LOAD_FIRST_DATA
  - fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY
- DECODE_ADDRESS, otherwise: stay. This includes address 3, which produces no transition and no write.
- WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: -> LOAD_DATA unconditionally (one cycle; the header is written by router_reg).
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE (fifo_full has priority)
  - else pkt_valid=0 -> LOAD_PARITY
  - else stay
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS
  - else low_packet_valid=1 -> LOAD_PARITY
  - else -> LOAD_DATA
- LOAD_PARITY: -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Soft reset: soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle. This overrides all other transitions. soft_reset on a non-selected port is ignored.
- Priority at every edge: resetn > soft_reset[addr_q] > state transitions.
- Latency:
  - header accepted to first payload write: 2 cycles (LFD then LD)
  - pkt_valid fall to rst_int_reg: 2 cycles (LP, CPE)

Decomposition:
- Shared package router_pkg: state encoding constants (DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR), ADDR_W, NUM_DEST, INVALID_ADDR=2'b11.
- No sub-module. Single always block for the state register plus addr_q, one combinational next-state block, continuous-assign output decode.

Test Plan:
- Good packet:
  - Stimulus: fifo_empty=3'b111, header 8'h16 (len 5, addr 2) with pkt_valid=1, 5 payload bytes, then the parity byte with pkt_valid=0.
  - Response: states DA, LFD, LD x5, LP, CPE, DA. write_enb_reg high for 6 cycles. busy=1 only in LFD, LP and CPE. rst_int_reg pulses 1 cycle.
- Busy destination:
  - Stimulus: header addr 1 with fifo_empty=3'b101.
  - Response: WAIT_TILL_EMPTY and busy=1 held. Setting fifo_empty[1]=1 gives LFD on the next cycle.
- Back-pressure:
  - Stimulus: in LOAD_DATA raise fifo_full for 3 cycles, then drop it with low_packet_valid=0, parity_done=0.
  - Response: FFS for 3 cycles with full_state=1 and write_enb_reg=0, then LAF, then LD.
  - Repeat with low_packet_valid=1: LAF then LP. Repeat with parity_done=1: LAF then DA.
- Invalid address:
  - Stimulus: header data_in=2'b11 with pkt_valid=1 for 4 cycles.
  - Response: stays in DA, detect_add=1, write_enb_reg=0, busy=0 throughout.
- Soft reset:
  - Stimulus: addr_q=0 in LOAD_DATA. Assert soft_reset=3'b010.
  - Response: no effect. Then soft_reset=3'b001 gives DA next cycle.
- Sync reset:
  - Stimulus: resetn=0 mid-packet (state LD), then released.
  - Response: DA at the next edge, not before it; detect_add=1, busy=0. A fresh header then proceeds normally.
